// File: rtl/bp_fe_lce_cmd_if.sv
// Bus bundle between the I-cache LCE command handler and its environment:
// CCE command channel, tag/data memory ports, response and transfer channels,
// plus the pulses that feed the downstream miss-request FSM.
interface bp_fe_lce_cmd_if #(
  parameter int lce_addr_width_p      = 22,
  parameter int lce_sets_p            = 64,
  parameter int ways_p                = 8,
  parameter int num_cce_p             = 1,
  parameter int num_lce_p             = 2,
  parameter int block_size_in_bytes_p = 64
) ();
  localparam int lg_sets_lp     = $clog2(lce_sets_p);
  localparam int lg_ways_lp     = $clog2(ways_p);
  localparam int lg_cce_lp      = (num_cce_p == 1) ? 1 : $clog2(num_cce_p);
  localparam int lg_lce_lp      = (num_lce_p == 1) ? 1 : $clog2(num_lce_p);
  localparam int lg_blk_lp      = $clog2(block_size_in_bytes_p);
  localparam int block_width_lp = 8 * block_size_in_bytes_p;
  localparam int tag_width_lp   = lce_addr_width_p - lg_sets_lp - lg_blk_lp;

  logic                        lce_ready;

  logic                        lce_cmd_v;
  logic                        lce_cmd_yumi;
  logic [lg_cce_lp-1:0]        lce_cmd_src;
  logic [2:0]                  lce_cmd_type;
  logic [lce_addr_width_p-1:0] lce_cmd_addr;
  logic [lg_ways_lp-1:0]       lce_cmd_way;
  logic [lg_lce_lp-1:0]        lce_cmd_tgt;
  logic [lg_ways_lp-1:0]       lce_cmd_tgt_way;

  logic                        tag_mem_v;
  logic [1:0]                  tag_mem_op;
  logic [lg_sets_lp-1:0]       tag_mem_set;
  logic [lg_ways_lp-1:0]       tag_mem_way;
  logic [tag_width_lp-1:0]     tag_mem_tag;

  logic                        data_mem_rd_v;
  logic [lg_sets_lp-1:0]       data_mem_set;
  logic [lg_ways_lp-1:0]       data_mem_way;
  logic [block_width_lp-1:0]   data_mem_data;

  logic                        lce_resp_v;
  logic [1:0]                  lce_resp_type;
  logic [lg_cce_lp-1:0]        lce_resp_dst;
  logic [lce_addr_width_p-1:0] lce_resp_addr;
  logic                        lce_resp_yumi;

  logic                        lce_tr_v;
  logic [lg_lce_lp-1:0]        lce_tr_dst;
  logic [lg_ways_lp-1:0]       lce_tr_way;
  logic [block_width_lp-1:0]   lce_tr_data;
  logic                        lce_tr_ready;

  logic                        tr_received;
  logic                        tag_set;
  logic                        tag_set_wakeup;

  // Environment side: issues commands, hosts the memories, sinks responses.
  modport master (
    input  lce_ready, lce_cmd_yumi,
           tag_mem_v, tag_mem_op, tag_mem_set, tag_mem_way, tag_mem_tag,
           data_mem_rd_v, data_mem_set, data_mem_way,
           lce_resp_v, lce_resp_type, lce_resp_dst, lce_resp_addr,
           lce_tr_v, lce_tr_dst, lce_tr_way, lce_tr_data,
           tr_received, tag_set, tag_set_wakeup,
    output lce_cmd_v, lce_cmd_src, lce_cmd_type, lce_cmd_addr, lce_cmd_way,
           lce_cmd_tgt, lce_cmd_tgt_way, data_mem_data, lce_resp_yumi, lce_tr_ready
  );

  // LCE command handler side.
  modport slave (
    output lce_ready, lce_cmd_yumi,
           tag_mem_v, tag_mem_op, tag_mem_set, tag_mem_way, tag_mem_tag,
           data_mem_rd_v, data_mem_set, data_mem_way,
           lce_resp_v, lce_resp_type, lce_resp_dst, lce_resp_addr,
           lce_tr_v, lce_tr_dst, lce_tr_way, lce_tr_data,
           tr_received, tag_set, tag_set_wakeup,
    input  lce_cmd_v, lce_cmd_src, lce_cmd_type, lce_cmd_addr, lce_cmd_way,
           lce_cmd_tgt, lce_cmd_tgt_way, data_mem_data, lce_resp_yumi, lce_tr_ready
  );
endinterface

// File: rtl/bp_fe_lce_cmd.sv
// Front-end I-cache LCE command handler. Sweeps the tag memory clear after
// reset, then applies CCE tag/state commands, returns sync/inv/wb responses
// and forwards blocks read from the data memory on transfer commands.
module bp_fe_lce_cmd #(
  parameter int lce_addr_width_p      = 22,
  parameter int lce_sets_p            = 64,
  parameter int ways_p                = 8,
  parameter int num_cce_p             = 1,
  parameter int num_lce_p             = 2,
  parameter int block_size_in_bytes_p = 64,
  localparam int lg_lce_lp = (num_lce_p == 1) ? 1 : $clog2(num_lce_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [lg_lce_lp-1:0] id_i,
  bp_fe_lce_cmd_if.slave       bus
);
  localparam int lg_sets_lp     = $clog2(lce_sets_p);
  localparam int lg_ways_lp     = $clog2(ways_p);
  localparam int lg_cce_lp      = (num_cce_p == 1) ? 1 : $clog2(num_cce_p);
  localparam int lg_blk_lp      = $clog2(block_size_in_bytes_p);
  localparam int block_width_lp = 8 * block_size_in_bytes_p;
  localparam int tag_width_lp   = lce_addr_width_p - lg_sets_lp - lg_blk_lp;
  localparam int sync_w_lp      = $clog2(num_cce_p + 1);

  localparam logic [sync_w_lp-1:0]  sync_max_lp = sync_w_lp'(num_cce_p);
  localparam logic [lg_sets_lp-1:0] last_set_lp = lg_sets_lp'(lce_sets_p - 1);

  typedef enum logic [2:0] {
    S_CLEAR, S_READY, S_SEND_RESP, S_TR_READ, S_TR_SEND
  } state_e;

  typedef enum logic [2:0] {
    CMD_SYNC           = 3'd0,
    CMD_SET_CLEAR      = 3'd1,
    CMD_TRANSFER       = 3'd2,
    CMD_WRITEBACK      = 3'd3,
    CMD_SET_TAG        = 3'd4,
    CMD_SET_TAG_WAKEUP = 3'd5,
    CMD_INVALIDATE     = 3'd6
  } cmd_e;

  typedef enum logic [1:0] {
    TAG_OP_CLEAR_SET = 2'd0,
    TAG_OP_SET_TAG   = 2'd1,
    TAG_OP_INVAL_WAY = 2'd2
  } tag_op_e;

  typedef enum logic [1:0] {
    RESP_SYNC_ACK = 2'd0,
    RESP_INV_ACK  = 2'd1,
    RESP_WB_NULL  = 2'd2
  } resp_e;

  state_e                      state, state_n;
  resp_e                       resp_type_r, resp_type_n;
  logic [lg_sets_lp-1:0]       clr_cnt;
  logic [sync_w_lp-1:0]        sync_cnt;
  logic [lce_addr_width_p-1:0] addr_r;
  logic [lg_cce_lp-1:0]        src_r;
  logic [lg_lce_lp-1:0]        tgt_r;
  logic [lg_ways_lp-1:0]       tgt_way_r;
  logic [block_width_lp-1:0]   tr_data_r;

  logic [lg_sets_lp-1:0]   cmd_set;
  logic [tag_width_lp-1:0] cmd_tag;

  assign cmd_set = bus.lce_cmd_addr[lg_blk_lp +: lg_sets_lp];
  assign cmd_tag = bus.lce_cmd_addr[lce_addr_width_p-1 -: tag_width_lp];

  assign bus.tr_received   = 1'b0;
  assign bus.lce_ready     = (state != S_CLEAR) && (sync_cnt == sync_max_lp);
  assign bus.lce_resp_type = resp_type_r;
  assign bus.lce_resp_dst  = src_r;
  assign bus.lce_resp_addr = addr_r;
  assign bus.lce_tr_dst    = tgt_r;
  assign bus.lce_tr_way    = tgt_way_r;
  assign bus.lce_tr_data   = tr_data_r;

  // Next-state decode and all per-cycle strobes; READY-state outputs are
  // combinational on the command so tag writes and pulses land in the yumi cycle.
  always_comb begin
    state_n            = state;
    resp_type_n        = resp_type_r;
    bus.lce_cmd_yumi   = 1'b0;
    bus.tag_mem_v      = 1'b0;
    bus.tag_mem_op     = TAG_OP_CLEAR_SET;
    bus.tag_mem_set    = '0;
    bus.tag_mem_way    = '0;
    bus.tag_mem_tag    = '0;
    bus.data_mem_rd_v  = 1'b0;
    bus.data_mem_set   = '0;
    bus.data_mem_way   = '0;
    bus.lce_resp_v     = 1'b0;
    bus.lce_tr_v       = 1'b0;
    bus.tag_set        = 1'b0;
    bus.tag_set_wakeup = 1'b0;

    unique case (state)
      S_CLEAR: begin
        // Gated by reset so nothing is written while reset is held.
        if (!reset_i) begin
          bus.tag_mem_v   = 1'b1;
          bus.tag_mem_set = clr_cnt;
          if (clr_cnt == last_set_lp) state_n = S_READY;
        end
      end

      S_READY: begin
        if (bus.lce_cmd_v) begin
          bus.lce_cmd_yumi = 1'b1;
          bus.tag_mem_set  = cmd_set;
          bus.tag_mem_way  = bus.lce_cmd_way;
          bus.tag_mem_tag  = cmd_tag;
          case (bus.lce_cmd_type)
            CMD_SET_CLEAR: begin
              bus.tag_mem_v = 1'b1;
            end
            CMD_SET_TAG: begin
              bus.tag_mem_v  = 1'b1;
              bus.tag_mem_op = TAG_OP_SET_TAG;
              bus.tag_set    = 1'b1;
            end
            CMD_SET_TAG_WAKEUP: begin
              bus.tag_mem_v      = 1'b1;
              bus.tag_mem_op     = TAG_OP_SET_TAG;
              bus.tag_set_wakeup = 1'b1;
            end
            CMD_INVALIDATE: begin
              bus.tag_mem_v  = 1'b1;
              bus.tag_mem_op = TAG_OP_INVAL_WAY;
              resp_type_n    = RESP_INV_ACK;
              state_n        = S_SEND_RESP;
            end
            CMD_SYNC: begin
              resp_type_n = RESP_SYNC_ACK;
              state_n     = S_SEND_RESP;
            end
            CMD_WRITEBACK: begin
              // The I-cache never holds dirty data.
              resp_type_n = RESP_WB_NULL;
              state_n     = S_SEND_RESP;
            end
            CMD_TRANSFER: begin
              bus.data_mem_rd_v = 1'b1;
              bus.data_mem_set  = cmd_set;
              bus.data_mem_way  = bus.lce_cmd_way;
              state_n           = S_TR_READ;
            end
            default: ;
          endcase
        end
      end

      S_SEND_RESP: begin
        bus.lce_resp_v = 1'b1;
        if (bus.lce_resp_yumi) state_n = S_READY;
      end

      // Data memory answers one cycle after the strobe; capture before offering.
      S_TR_READ: begin
        state_n = S_TR_SEND;
      end

      S_TR_SEND: begin
        bus.lce_tr_v = 1'b1;
        if (bus.lce_tr_ready) state_n = S_READY;
      end

      default: state_n = S_CLEAR;
    endcase
  end

  // State, sweep/sync counters and the command fields held for response/transfer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= S_CLEAR;
      resp_type_r <= RESP_SYNC_ACK;
      clr_cnt     <= '0;
      sync_cnt    <= '0;
      addr_r      <= '0;
      src_r       <= '0;
      tgt_r       <= '0;
      tgt_way_r   <= '0;
      tr_data_r   <= '0;
    end else begin
      state       <= state_n;
      resp_type_r <= resp_type_n;
      if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (state == S_SEND_RESP && bus.lce_resp_yumi
          && resp_type_r == RESP_SYNC_ACK && sync_cnt != sync_max_lp)
        sync_cnt <= sync_cnt + 1'b1;
      if (bus.lce_cmd_yumi) begin
        addr_r    <= bus.lce_cmd_addr;
        src_r     <= bus.lce_cmd_src;
        tgt_r     <= bus.lce_cmd_tgt;
        tgt_way_r <= bus.lce_cmd_tgt_way;
      end
      if (state == S_TR_READ) tr_data_r <= bus.data_mem_data;
    end
  end

  // A CCE never asks an LCE to forward a block to itself.
  always_ff @(posedge clk_i) begin
    if (!reset_i && bus.lce_cmd_yumi && bus.lce_cmd_type == CMD_TRANSFER)
      assert (bus.lce_cmd_tgt != id_i);
  end
endmodule

// File: tb/tb_bp_fe_lce_cmd.sv
// Bench for bp_fe_lce_cmd: reset sweep, sync handshakes, a table of
// single-cycle tag commands, hand-written transfer/invalidate/reset
// sequences, then random commands against a behavioural model.
module tb_bp_fe_lce_cmd;
  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] id;

  always #5 clk = ~clk;

  bp_fe_lce_cmd_if #(.num_cce_p(2)) bus ();

  bp_fe_lce_cmd #(.num_cce_p(2)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .id_i   (id),
    .bus    (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Behavioural data memory: registered read, junk when not strobed.
  logic [511:0] mem [64][8];
  always @(posedge clk) begin
    if (bus.data_mem_rd_v) bus.data_mem_data <= mem[bus.data_mem_set][bus.data_mem_way];
    else                   bus.data_mem_data <= {16{32'($urandom)}};
  end

  function automatic logic [5:0] set_of(input logic [21:0] a);
    return 6'((a / 64) % 64);
  endfunction
  function automatic logic [9:0] tag_of(input logic [21:0] a);
    return 10'(a / 4096);
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask

  // Present a command and sample the cycle it is consumed (bounded wait).
  task automatic issue(input logic [2:0] t, input logic [21:0] a, input logic [2:0] w,
                       input logic s, input logic tg, input logic [2:0] tw);
    bus.lce_cmd_v       = 1'b1;
    bus.lce_cmd_type    = t;
    bus.lce_cmd_addr    = a;
    bus.lce_cmd_way     = w;
    bus.lce_cmd_src     = s;
    bus.lce_cmd_tgt     = tg;
    bus.lce_cmd_tgt_way = tw;
    smp();
    for (int n = 0; n < 20 && !bus.lce_cmd_yumi; n++) begin
      adv();
      smp();
    end
    chk("cmd_yumi", bus.lce_cmd_yumi, 1);
  endtask

  task automatic wait_tr();
    for (int n = 0; n < 10 && !bus.lce_tr_v; n++) begin
      adv();
      smp();
    end
    chk("tr_v_arrives", bus.lce_tr_v, 1);
  endtask

  typedef struct {
    logic [2:0]  typ;
    logic [21:0] addr;
    logic [2:0]  way;
    logic        tag_v;
    logic [1:0]  op;
    logic [5:0]  set;
    logic [9:0]  tag;
    logic        ts;
    logic        tsw;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : main
    logic [2:0]  t;
    logic [21:0] a;
    logic [2:0]  w, tw;
    logic        s;
    int unsigned stall;

    for (int si = 0; si < 64; si++)
      for (int wi = 0; wi < 8; wi++)
        for (int k = 0; k < 16; k++) mem[si][wi][k*32 +: 32] = $urandom;
    mem[3][2] = {64{8'hA5}};

    vecs[0] = '{3'd5, 22'h12340,  3'd5, 1'b1, 2'd1, 6'h0D, 10'h012, 1'b0, 1'b1};
    vecs[1] = '{3'd4, 22'h3FFFC0, 3'd7, 1'b1, 2'd1, 6'h3F, 10'h3FF, 1'b1, 1'b0};
    vecs[2] = '{3'd1, 22'h00040,  3'd3, 1'b1, 2'd0, 6'h01, 10'h000, 1'b0, 1'b0};
    vecs[3] = '{3'd7, 22'h2AAAA,  3'd1, 1'b0, 2'd0, 6'h00, 10'h000, 1'b0, 1'b0};
    vecs[4] = '{3'd4, 22'h00000,  3'd0, 1'b1, 2'd1, 6'h00, 10'h000, 1'b1, 1'b0};
    vecs[5] = '{3'd1, 22'h3FFFFF, 3'd6, 1'b1, 2'd0, 6'h3F, 10'h000, 1'b0, 1'b0};

    id = 1'b0;
    reset = 1'b1;
    bus.lce_cmd_v = 1'b1;  bus.lce_cmd_type = 3'd7;  bus.lce_cmd_addr = '0;
    bus.lce_cmd_way = '0;  bus.lce_cmd_src = '0;     bus.lce_cmd_tgt = 1'b1;
    bus.lce_cmd_tgt_way = '0;
    bus.lce_resp_yumi = 1'b0;
    bus.lce_tr_ready = 1'b0;

    // Reset values, then the full clear sweep while a command waits.
    smp();
    chk("rst_tag_v", bus.tag_mem_v, 0);
    chk("rst_yumi", bus.lce_cmd_yumi, 0);
    chk("rst_resp_v", bus.lce_resp_v, 0);
    chk("rst_tr_v", bus.lce_tr_v, 0);
    chk("rst_ready", bus.lce_ready, 0);
    adv();
    adv();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      smp();
      chk("sweep_tag_v", bus.tag_mem_v, 1);
      chk("sweep_op", bus.tag_mem_op, 0);
      chk("sweep_set", bus.tag_mem_set, i);
      chk("sweep_yumi", bus.lce_cmd_yumi, 0);
      chk("sweep_ready", bus.lce_ready, 0);
      adv();
    end
    smp();
    chk("post_sweep_yumi", bus.lce_cmd_yumi, 1);
    chk("illegal_no_tag_v", bus.tag_mem_v, 0);
    adv();
    bus.lce_cmd_v = 1'b0;

    // Two syncs, one per CCE, each response held off for 3 cycles.
    for (int k = 0; k < 2; k++) begin
      a = 22'h01000 + 22'(k * 64);
      issue(3'd0, a, 3'd0, 1'(k), 1'b1, 3'd0);
      chk("sync_ready_before", bus.lce_ready, 0);
      adv();
      bus.lce_cmd_v = 1'b0;
      for (int n = 0; n < 3; n++) begin
        smp();
        chk("sync_resp_v", bus.lce_resp_v, 1);
        chk("sync_resp_type", bus.lce_resp_type, 0);
        chk("sync_resp_dst", bus.lce_resp_dst, k);
        chk("sync_resp_addr", bus.lce_resp_addr, a);
        adv();
      end
      bus.lce_resp_yumi = 1'b1;
      smp();
      chk("sync_resp_v_hs", bus.lce_resp_v, 1);
      chk("sync_ready_hs", bus.lce_ready, 0);
      adv();
      bus.lce_resp_yumi = 1'b0;
      smp();
      chk("sync_ready_after", bus.lce_ready, (k == 1) ? 1 : 0);
      chk("sync_resp_v_done", bus.lce_resp_v, 0);
      adv();
    end

    // Single-cycle tag commands from the table.
    foreach (vecs[i]) begin
      issue(vecs[i].typ, vecs[i].addr, vecs[i].way, 1'b0, 1'b1, 3'd0);
      chk("vec_tag_v", bus.tag_mem_v, vecs[i].tag_v);
      if (vecs[i].tag_v) begin
        chk("vec_op", bus.tag_mem_op, vecs[i].op);
        chk("vec_set", bus.tag_mem_set, vecs[i].set);
        if (vecs[i].op == 2'd1) begin
          chk("vec_way", bus.tag_mem_way, vecs[i].way);
          chk("vec_tag", bus.tag_mem_tag, vecs[i].tag);
        end
      end
      chk("vec_tag_set", bus.tag_set, vecs[i].ts);
      chk("vec_tag_set_wakeup", bus.tag_set_wakeup, vecs[i].tsw);
      adv();
      bus.lce_cmd_v = 1'b0;
      smp();
      chk("vec_pulse_gone", {bus.tag_set, bus.tag_set_wakeup, bus.tag_mem_v}, 0);
      adv();
    end

    // Transfer from set 3 way 2 with 4 cycles of backpressure and a queued command.
    issue(3'd2, 22'h050C0, 3'd2, 1'b1, 1'b1, 3'd6);
    chk("tr_rd_v", bus.data_mem_rd_v, 1);
    chk("tr_rd_set", bus.data_mem_set, 3);
    chk("tr_rd_way", bus.data_mem_way, 2);
    adv();
    bus.lce_cmd_v = 1'b0;
    smp();
    wait_tr();
    adv();
    bus.lce_cmd_v = 1'b1;
    bus.lce_cmd_type = 3'd1;
    for (int n = 0; n < 4; n++) begin
      smp();
      chk("tr_v_hold", bus.lce_tr_v, 1);
      chk("tr_data_hold", bus.lce_tr_data, {64{8'hA5}});
      chk("tr_dst_hold", bus.lce_tr_dst, 1);
      chk("tr_way_hold", bus.lce_tr_way, 6);
      chk("tr_blocks_cmd", bus.lce_cmd_yumi, 0);
      adv();
    end
    bus.lce_tr_ready = 1'b1;
    smp();
    chk("tr_v_hs", bus.lce_tr_v, 1);
    chk("tr_data_hs", bus.lce_tr_data, {64{8'hA5}});
    adv();
    bus.lce_tr_ready = 1'b0;
    smp();
    chk("tr_v_done", bus.lce_tr_v, 0);
    chk("tr_back_ready", bus.lce_cmd_yumi, 1);
    adv();
    bus.lce_cmd_v = 1'b0;

    // Invalidate way 4 with a set_tag queued behind a stalled response.
    issue(3'd6, 22'h0ABC0, 3'd4, 1'b1, 1'b1, 3'd0);
    chk("inv_tag_v", bus.tag_mem_v, 1);
    chk("inv_op", bus.tag_mem_op, 2);
    chk("inv_set", bus.tag_mem_set, 6'h2F);
    chk("inv_way", bus.tag_mem_way, 4);
    adv();
    bus.lce_cmd_type = 3'd4;
    bus.lce_cmd_addr = 22'h01040;
    bus.lce_cmd_way  = 3'd1;
    for (int n = 0; n < 5; n++) begin
      smp();
      chk("inv_resp_v", bus.lce_resp_v, 1);
      chk("inv_resp_type", bus.lce_resp_type, 1);
      chk("inv_resp_dst", bus.lce_resp_dst, 1);
      chk("inv_resp_addr", bus.lce_resp_addr, 22'h0ABC0);
      chk("inv_blocks_cmd", bus.lce_cmd_yumi, 0);
      adv();
    end
    bus.lce_resp_yumi = 1'b1;
    smp();
    chk("inv_hs_blocks_cmd", bus.lce_cmd_yumi, 0);
    adv();
    bus.lce_resp_yumi = 1'b0;
    smp();
    chk("queued_set_tag_yumi", bus.lce_cmd_yumi, 1);
    chk("queued_tag_set", bus.tag_set, 1);
    chk("queued_resp_v", bus.lce_resp_v, 0);
    adv();
    bus.lce_cmd_v = 1'b0;

    // Writeback answers with wb_null.
    issue(3'd3, 22'h3F000, 3'd0, 1'b0, 1'b1, 3'd0);
    adv();
    bus.lce_cmd_v = 1'b0;
    bus.lce_resp_yumi = 1'b1;
    smp();
    chk("wb_resp_v", bus.lce_resp_v, 1);
    chk("wb_resp_type", bus.lce_resp_type, 2);
    chk("wb_resp_addr", bus.lce_resp_addr, 22'h3F000);
    adv();
    bus.lce_resp_yumi = 1'b0;
    smp();
    chk("wb_resp_done", bus.lce_resp_v, 0);
    adv();

    // Random commands against the behavioural rules.
    for (int it = 0; it < 150; it++) begin
      t  = 3'($urandom_range(0, 7));
      a  = 22'($urandom);
      w  = 3'($urandom);
      tw = 3'($urandom);
      s  = 1'($urandom);
      issue(t, a, w, s, 1'b1, tw);
      chk("rnd_ready", bus.lce_ready, 1);
      chk("rnd_tag_v", bus.tag_mem_v, (t == 1 || t == 4 || t == 5 || t == 6) ? 1 : 0);
      if (t == 1 || t == 4 || t == 5 || t == 6) begin
        chk("rnd_op", bus.tag_mem_op, (t == 1) ? 0 : (t == 6) ? 2 : 1);
        chk("rnd_set", bus.tag_mem_set, set_of(a));
        if (t != 1) chk("rnd_way", bus.tag_mem_way, w);
        if (t == 4 || t == 5) chk("rnd_tag", bus.tag_mem_tag, tag_of(a));
      end
      chk("rnd_tag_set", bus.tag_set, (t == 4) ? 1 : 0);
      chk("rnd_tag_set_wakeup", bus.tag_set_wakeup, (t == 5) ? 1 : 0);
      chk("rnd_rd_v", bus.data_mem_rd_v, (t == 2) ? 1 : 0);
      adv();
      bus.lce_cmd_v = 1'b0;
      stall = $urandom_range(0, 3);
      if (t == 0 || t == 3 || t == 6) begin
        for (int n = 0; n < int'(stall); n++) begin
          smp();
          chk("rnd_resp_v_stall", bus.lce_resp_v, 1);
          adv();
        end
        bus.lce_resp_yumi = 1'b1;
        smp();
        chk("rnd_resp_v", bus.lce_resp_v, 1);
        chk("rnd_resp_type", bus.lce_resp_type, (t == 0) ? 0 : (t == 6) ? 1 : 2);
        chk("rnd_resp_dst", bus.lce_resp_dst, s);
        chk("rnd_resp_addr", bus.lce_resp_addr, a);
        adv();
        bus.lce_resp_yumi = 1'b0;
      end else if (t == 2) begin
        smp();
        wait_tr();
        adv();
        for (int n = 0; n < int'(stall); n++) begin
          smp();
          chk("rnd_tr_data_stall", bus.lce_tr_data, mem[set_of(a)][w]);
          adv();
        end
        bus.lce_tr_ready = 1'b1;
        smp();
        chk("rnd_tr_v", bus.lce_tr_v, 1);
        chk("rnd_tr_data", bus.lce_tr_data, mem[set_of(a)][w]);
        chk("rnd_tr_dst", bus.lce_tr_dst, 1);
        chk("rnd_tr_way", bus.lce_tr_way, tw);
        adv();
        bus.lce_tr_ready = 1'b0;
      end
    end

    // Reset while a transfer is stalled: valid drops, sweep restarts at set 0.
    issue(3'd2, 22'h00180, 3'd1, 1'b0, 1'b1, 3'd3);
    adv();
    bus.lce_cmd_v = 1'b0;
    smp();
    wait_tr();
    adv();
    reset = 1'b1;
    bus.lce_cmd_v = 1'b1;
    bus.lce_cmd_type = 3'd7;
    adv();
    reset = 1'b0;
    smp();
    chk("rst_tr_v_drop", bus.lce_tr_v, 0);
    chk("rst_sweep_tag_v", bus.tag_mem_v, 1);
    chk("rst_sweep_set0", bus.tag_mem_set, 0);
    chk("rst_sweep_ready", bus.lce_ready, 0);
    for (int i = 1; i < 64; i++) begin
      adv();
      smp();
      chk("rst_sweep_set", bus.tag_mem_set, i);
      chk("rst_sweep_yumi", bus.lce_cmd_yumi, 0);
    end
    adv();
    smp();
    chk("rst_sweep_done_yumi", bus.lce_cmd_yumi, 1);
    chk("rst_sync_cleared", bus.lce_ready, 0);
    adv();
    bus.lce_cmd_v = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bp_fe_lce_cmd.md
Name: bp_fe_lce_cmd

Overview:
- Front-end I-cache LCE command handler. Consumes CCE→LCE commands and applies tag/state updates to the I-cache tag memory.
- Services transfers by reading the data memory. Returns sync/invalidate/writeback responses.
- Drives tr_received_o, tag_set_o and tag_set_wakeup_o, which feed the LCE miss-request FSM directly downstream.

Parameters:
- lce_addr_width_p, 22, physical address width.
- lce_sets_p, 64, sets; lg_sets=clog2.
- ways_p, 8, ways; lg_ways=clog2.
- num_cce_p, 1, CCEs; lg_cce=safe_clog2.
- num_lce_p, 2, LCEs; lg_lce=safe_clog2.
- block_size_in_bytes_p, 64, block bytes; lg_blk=clog2.
- block_width_lp, 8*block_size_in_bytes_p, block data bits.
- tag_width_lp, lce_addr_width_p-lg_sets-lg_blk.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- id_i  in  lg_lce  this LCE id.
- lce_ready_o  out  1  init complete.
- lce_cmd_v_i  in  1  command valid.
- lce_cmd_yumi_o  out  1  command consumed.
- lce_cmd_src_i  in  lg_cce  issuing CCE.
- lce_cmd_type_i  in  3  0 sync, 1 set_clear, 2 transfer, 3 writeback, 4 set_tag, 5 set_tag_wakeup, 6 invalidate.
- lce_cmd_addr_i  in  lce_addr_width_p  block address.
- lce_cmd_way_i  in  lg_ways  target way.
- lce_cmd_tgt_i  in  lg_lce  transfer target LCE.
- lce_cmd_tgt_way_i  in  lg_ways  transfer target way.
- tag_mem_v_o  out  1  tag write strobe; always accepted.
- tag_mem_op_o  out  2  0 clear set, 1 set tag+valid, 2 invalidate way.
- tag_mem_set_o  out  lg_sets  index.
- tag_mem_way_o  out  lg_ways  way.
- tag_mem_tag_o  out  tag_width_lp  tag.
- data_mem_rd_v_o  out  1  data read strobe.
- data_mem_set_o  out  lg_sets  index.
- data_mem_way_o  out  lg_ways  way.
- data_mem_data_i  in  block_width_lp  read data, 1 cycle after strobe.
- lce_resp_v_o  out  1  response valid.
- lce_resp_type_o  out  2  0 sync_ack, 1 inv_ack, 2 wb_null.
- lce_resp_dst_o  out  lg_cce  destination CCE.
- lce_resp_addr_o  out  lce_addr_width_p  address.
- lce_resp_yumi_i  in  1  response taken.
- lce_tr_v_o  out  1  transfer valid.
- lce_tr_dst_o  out  lg_lce  target LCE.
- lce_tr_way_o  out  lg_ways  target way.
- lce_tr_data_o  out  block_width_lp  block.
- lce_tr_ready_i  in  1  transfer accepted when high with valid.
- tr_received_o  out  1  1-cycle pulse.
- tag_set_o  out  1  1-cycle pulse.
- tag_set_wakeup_o  out  1  1-cycle pulse.

Behaviour:
- Field mapping: set = addr[lg_blk +: lg_sets]; tag = addr[msb -: tag_width_lp]. tr_received_o is asserted by external transfer-receive logic; here it is held 0 and exists only for interface completeness.
- Reset values: all outputs 0, state CLEAR, set counter 0, sync counter 0, lce_ready_o=0.
- CLEAR: each cycle tag_mem_v_o=1, op=0, set=counter, counter++. After set lce_sets_p-1 is written, go to READY. Commands are not consumed during CLEAR (yumi=0).
- READY, when cmd_v_i (yumi in the same cycle except where noted):
  - set_clear: clear tag write at set.
  - set_tag: op 1 write plus tag_set_o pulse.
  - set_tag_wakeup: op 1 write plus tag_set_wakeup_o pulse.
  - invalidate: op 2 write, then go to SEND_RESP with type inv_ack.
  - sync: go to SEND_RESP with type sync_ack.
  - writeback: go to SEND_RESP with type wb_null. The I-cache is never dirty.
  - transfer: data_mem_rd_v_o=1, go to TR_SEND.
- Latching: cmd addr, src, tgt and tgt_way are registered on yumi. Resp dst = latched src; resp addr = latched addr.
- SEND_RESP: lce_resp_v_o=1 until yumi_i, then go to READY. On a sync_ack handshake the sync counter increments, saturating at num_cce_p.
- TR_SEND:
  - Capture data_mem_data_i in the cycle after the read strobe; hold it in a register.
  - lce_tr_v_o=1 until lce_tr_ready_i, then go to READY.
  - Backpressure keeps data/dst/way stable.
- Command ordering: no new command is accepted while in SEND_RESP or TR_SEND.
- lce_ready_o = (state != CLEAR) && (sync_cnt == num_cce_p). It is sticky until reset.
- Pulses (tag_set_o, tag_set_wakeup_o) assert exactly in the yumi cycle.
- Reset mid-operation: in any state, reset returns to CLEAR, drops all valids the next cycle, clears counters and restarts the full set sweep.
- Illegal type 7: consumed, no side effects.

Test Plan:
- Reset, no stimulus -> tag_mem_v_o high 64 consecutive cycles, sets 0..63 with op 0. lce_ready_o=0 and cmd_yumi_o=0 throughout.
- num_cce_p=2, two syncs (src 0 then 1), resp yumi after 3 stall cycles each -> resp_type 0, dst 0 then 1. lce_ready_o rises the cycle after the second yumi.
- set_tag_wakeup addr 0x12340, way 5 -> same-cycle tag write: op 1, set 0x0D, way 5, tag 0x12. One-cycle tag_set_wakeup_o; tag_set_o stays 0.
- transfer set 3, way 2, tgt 1, tgt_way 6; data_mem returns 0xA5 pattern; lce_tr_ready_i low 4 cycles -> tr data/dst 1/way 6 stable until ready. Returns to READY.
- invalidate way 4 while resp yumi is low for 5 cycles, with a set_tag queued -> set_tag is not yumi'd until the cycle after inv_ack yumi.
- reset asserted in TR_SEND -> lce_tr_v_o=0 next cycle, CLEAR sweep restarts at set 0.
